spart_bus_arbiter: RTL

//   Shares the SPART I/O bus (iocs/iorw/ioaddr/databus) between two requesters (e.g. baud

---
 rtl/spart_bus_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spart_bus_arbiter.sv
// Round-robin arbiter that gives two requesters single read/write transactions on the SPART I/O bus.
// Optional macro SPART_ARB_LOCK_EN lets an owner hold the bus across transactions for atomic sequences.
module spart_bus_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              iocs,
  output logic              iorw,
  output logic [ADDR_W-1:0] ioaddr,
  inout  wire  [DATA_W-1:0] databus
);

  typedef enum logic [1:0] {IDLE, XFER, CAPT, ACK} state_t;

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              hold;

  logic              gnt_vld;
  logic              gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_lock;

`ifdef SPART_ARB_LOCK_EN
  assign sel_lock = gnt ? lock1 : lock0;
`else
  logic unused_lock;
  assign unused_lock = ^{lock0, lock1};
  assign sel_lock    = 1'b0;
`endif

  // A held lock restricts the choice to the current owner; otherwise the tie goes away from last_owner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (hold) begin
      gnt     = owner;
      gnt_vld = owner ? req1 : req0;
    end else if (req0 && req1) begin
      gnt     = ~last_owner;
      gnt_vld = 1'b1;
    end else if (req0 || req1) begin
      gnt     = req1;
      gnt_vld = 1'b1;
    end
  end

  assign sel_we    = gnt ? we1    : we0;
  assign sel_addr  = gnt ? addr1  : addr0;
  assign sel_wdata = gnt ? wdata1 : wdata0;

  // Only a write cycle with chip select active puts data on the bus.
  assign databus = (iocs && !iorw) ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      hold       <= 1'b0;
      iocs       <= 1'b0;
      iorw       <= 1'b1;
      ioaddr     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          iocs <= 1'b0;
          iorw <= 1'b1;
          if (gnt_vld) begin
            owner   <= gnt;
            we_q    <= sel_we;
            wdata_q <= sel_wdata;
            hold    <= sel_lock;
            iocs    <= 1'b1;
            iorw    <= ~sel_we;
            ioaddr  <= sel_addr;
            state   <= XFER;
          end
        end
        XFER: begin
          if (we_q) begin
            iocs  <= 1'b0;
            iorw  <= 1'b1;
            ack0  <= ~owner;
            ack1  <= owner;
            state <= ACK;
          end else begin
            state <= CAPT;
          end
        end
        CAPT: begin
          if (owner) rdata1 <= databus;
          else       rdata0 <= databus;
          iocs  <= 1'b0;
          ack0  <= ~owner;
          ack1  <= owner;
          state <= ACK;
        end
        ACK: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
